// File: rtl/pipe_hazard_ctrl.sv
// Central stall/flush controller for the 5-stage RV32I pipeline (IF, ID, EX, MEM, WB).
// Resolves load-use, branch-redirect and memory-wait hazards and keeps saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned MEM_TIMEOUT = 255
) (
    input  logic             clk_in,
    input  logic             rst_n_in,
    input  logic             rdy_in,
    input  logic             id_read_flag_1,
    input  logic [4:0]       id_reg_read_1,
    input  logic             id_read_flag_2,
    input  logic [4:0]       id_reg_read_2,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd_addr,
    input  logic             ex_br_taken,
    input  logic [31:0]      ex_br_target,
    input  logic             if_busy,
    input  logic             if_done,
    input  logic             mem_busy,
    output logic [4:0]       stall,
    output logic             flush_if_id,
    output logic             flush_id_ex,
    output logic             if_discard,
    output logic             pc_redirect,
    output logic [31:0]      pc_target,
    output logic             mem_timeout,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    localparam int unsigned TMR_W = (MEM_TIMEOUT > 0) ? $clog2(MEM_TIMEOUT + 1) : 1;
    localparam logic [TMR_W-1:0] TMR_MAX = TMR_W'(MEM_TIMEOUT);

    typedef enum logic {
        StRun,
        StRedirWait
    } state_t;

    state_t           state_q, state_d;
    logic [31:0]      tgt_q, tgt_d;
    logic [TMR_W-1:0] tmr_q, tmr_d;
    logic             timeout_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             lu_hz;

    // x0 is hardwired to zero, so a load targeting it never creates a dependency.
    assign lu_hz = ex_is_load && (ex_rd_addr != 5'd0) &&
                   ((id_read_flag_1 && (id_reg_read_1 == ex_rd_addr)) ||
                    (id_read_flag_2 && (id_reg_read_2 == ex_rd_addr)));

    always_comb begin
        stall       = 5'b00000;
        flush_if_id = 1'b0;
        flush_id_ex = 1'b0;
        if_discard  = 1'b0;
        pc_redirect = 1'b0;
        pc_target   = 32'd0;
        state_d     = state_q;
        tgt_d       = tgt_q;

        if (!rst_n_in) begin
            stall = 5'b00000;
        end else if (!rdy_in || mem_busy) begin
            // EX is held under mem_busy, so a taken branch is simply re-presented later.
            stall = 5'b11111;
        end else if (state_q == StRedirWait) begin
            stall[0]    = 1'b1;
            flush_if_id = 1'b1;
            if (if_done) begin
                if_discard  = 1'b1;
                pc_redirect = 1'b1;
                pc_target   = tgt_q;
                state_d     = StRun;
            end
        end else if (ex_br_taken) begin
            flush_if_id = 1'b1;
            flush_id_ex = 1'b1;
            if (!if_busy && !if_done) begin
                pc_redirect = 1'b1;
                pc_target   = ex_br_target;
            end else begin
                // Fetch in flight: park the target until the stale word comes back.
                stall[0]   = 1'b1;
                if_discard = if_done;
                tgt_d      = ex_br_target;
                state_d    = StRedirWait;
            end
        end else if (lu_hz) begin
            stall       = 5'b00011;
            flush_id_ex = 1'b1;
        end
    end

    always_comb begin
        tmr_d = tmr_q;
        if (!mem_busy) begin
            tmr_d = '0;
        end else if (tmr_q != TMR_MAX) begin
            tmr_d = tmr_q + 1'b1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q     <= StRun;
            tgt_q       <= 32'd0;
            tmr_q       <= '0;
            timeout_q   <= 1'b0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else if (rdy_in) begin
            state_q <= state_d;
            tgt_q   <= tgt_d;
            tmr_q   <= tmr_d;
            if ((MEM_TIMEOUT != 0) && mem_busy && (tmr_d == TMR_MAX)) begin
                timeout_q <= 1'b1;
            end
            if (stall[0] && (stall_cnt_q != '1)) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end
            if (pc_redirect && (flush_cnt_q != '1)) begin
                flush_cnt_q <= flush_cnt_q + 1'b1;
            end
        end
    end

    assign mem_timeout = timeout_q;
    assign stall_cnt   = stall_cnt_q;
    assign flush_cnt   = flush_cnt_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: directed scenarios plus random traffic against a behavioural model.
// Narrow counters and a short memory timeout keep saturation and timeout reachable.
module tb_pipe_hazard_ctrl;

    localparam int unsigned CW  = 8;
    localparam int unsigned TO  = 3;
    localparam int          SAT = 255;

    logic          clk_in = 1'b0;
    logic          rst_n_in = 1'b0;
    logic          rdy_in, id_read_flag_1, id_read_flag_2, ex_is_load, ex_br_taken;
    logic [4:0]    id_reg_read_1, id_reg_read_2, ex_rd_addr;
    logic [31:0]   ex_br_target;
    logic          if_busy, if_done, mem_busy;
    logic [4:0]    stall;
    logic          flush_if_id, flush_id_ex, if_discard, pc_redirect, mem_timeout;
    logic [31:0]   pc_target;
    logic [CW-1:0] stall_cnt, flush_cnt;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk_in = ~clk_in;

    pipe_hazard_ctrl #(
        .CNT_W      (CW),
        .MEM_TIMEOUT(TO)
    ) dut (
        .clk_in        (clk_in),
        .rst_n_in      (rst_n_in),
        .rdy_in        (rdy_in),
        .id_read_flag_1(id_read_flag_1),
        .id_reg_read_1 (id_reg_read_1),
        .id_read_flag_2(id_read_flag_2),
        .id_reg_read_2 (id_reg_read_2),
        .ex_is_load    (ex_is_load),
        .ex_rd_addr    (ex_rd_addr),
        .ex_br_taken   (ex_br_taken),
        .ex_br_target  (ex_br_target),
        .if_busy       (if_busy),
        .if_done       (if_done),
        .mem_busy      (mem_busy),
        .stall         (stall),
        .flush_if_id   (flush_if_id),
        .flush_id_ex   (flush_id_ex),
        .if_discard    (if_discard),
        .pc_redirect   (pc_redirect),
        .pc_target     (pc_target),
        .mem_timeout   (mem_timeout),
        .stall_cnt     (stall_cnt),
        .flush_cnt     (flush_cnt)
    );

    // Reference model: a pending-redirect flag, unbounded event tallies and a busy run length.
    bit          m_pend;
    logic [31:0] m_tgt;
    int          m_stalls, m_flushes, m_busy_run;
    bit          m_to;
    logic [4:0]  e_stall;
    logic        e_fif, e_fie, e_disc, e_redir, hz;
    logic [31:0] e_tgt;
    logic [40:0] exp_o, dut_o;
    logic [16:0] exp_c, dut_c;

    always_comb begin
        hz = ex_is_load && (ex_rd_addr != 5'd0) &&
             ((id_read_flag_1 && id_reg_read_1 == ex_rd_addr) ||
              (id_read_flag_2 && id_reg_read_2 == ex_rd_addr));
        e_stall = 5'd0; e_fif = 1'b0; e_fie = 1'b0; e_disc = 1'b0; e_redir = 1'b0; e_tgt = 32'd0;
        if (rst_n_in) begin
            if (!rdy_in || mem_busy) begin
                e_stall = 5'h1F;
            end else if (m_pend) begin
                e_stall = 5'd1; e_fif = 1'b1;
                if (if_done) begin e_disc = 1'b1; e_redir = 1'b1; e_tgt = m_tgt; end
            end else if (ex_br_taken) begin
                e_fif = 1'b1; e_fie = 1'b1;
                if (!if_busy && !if_done) begin e_redir = 1'b1; e_tgt = ex_br_target; end
                else begin e_stall = 5'd1; e_disc = if_done; end
            end else if (hz) begin
                e_stall = 5'b00011; e_fie = 1'b1;
            end
        end
        exp_o = {e_stall, e_fif, e_fie, e_disc, e_redir, e_tgt};
        dut_o = {stall, flush_if_id, flush_id_ex, if_discard, pc_redirect, pc_target};
        exp_c = {m_to, (m_stalls > SAT) ? 8'hFF : CW'(m_stalls),
                 (m_flushes > SAT) ? 8'hFF : CW'(m_flushes)};
        dut_c = {mem_timeout, stall_cnt, flush_cnt};
    end

    always @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            m_pend <= 1'b0; m_tgt <= 32'd0; m_stalls <= 0; m_flushes <= 0;
            m_busy_run <= 0; m_to <= 1'b0;
        end else if (rdy_in) begin
            m_busy_run <= mem_busy ? m_busy_run + 1 : 0;
            if (mem_busy && (m_busy_run + 1 >= TO)) m_to <= 1'b1;
            if (e_stall[0]) m_stalls <= m_stalls + 1;
            if (e_redir) m_flushes <= m_flushes + 1;
            if (!mem_busy) begin
                if (m_pend) begin
                    if (if_done) m_pend <= 1'b0;
                end else if (ex_br_taken && (if_busy || if_done)) begin
                    m_pend <= 1'b1; m_tgt <= ex_br_target;
                end
            end
        end
    end

    task automatic idle_inputs();
        rdy_in = 1'b1; id_read_flag_1 = 1'b0; id_reg_read_1 = 5'd0; id_read_flag_2 = 1'b0;
        id_reg_read_2 = 5'd0; ex_is_load = 1'b0; ex_rd_addr = 5'd0; ex_br_taken = 1'b0;
        ex_br_target = 32'd0; if_busy = 1'b0; if_done = 1'b0; mem_busy = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        rdy_in = 1'b0;
        repeat (2) @(posedge clk_in);
        #1;
        n_chk++;
        if (dut_o !== 41'd0) $display("FAIL reset_outputs: got %h want 0", dut_o);
        else n_pass++;
        n_chk++;
        if (dut_c !== 17'd0) $display("FAIL reset_counters: got %h want 0", dut_c);
        else n_pass++;
        rdy_in = 1'b1;
        rst_n_in = 1'b1;
        @(posedge clk_in); #1;
    endtask

    task automatic test_load_use();
        for (int c = 0; c < 3; c++) begin
            idle_inputs();
            id_read_flag_1 = 1'b1; id_reg_read_1 = 5'd3;
            id_read_flag_2 = 1'b1; id_reg_read_2 = (c == 2) ? 5'd0 : 5'd5;
            ex_is_load = (c != 1);
            ex_rd_addr = (c == 2) ? 5'd0 : 5'd5;
            @(negedge clk_in);
            n_chk++;
            if ({stall, flush_id_ex} !== ((c == 0) ? 6'b000111 : 6'b000000))
                $display("FAIL load_use c%0d: stall/flush_id_ex got %b/%b", c, stall, flush_id_ex);
            else n_pass++;
            n_chk++;
            if (dut_o !== exp_o) $display("FAIL load_use_model c%0d: got %h want %h", c, dut_o, exp_o);
            else n_pass++;
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_branch_now();
        n_chk++;
        if (flush_cnt !== 8'd0) $display("FAIL branch_now_pre: flush_cnt got %0d want 0", flush_cnt);
        else n_pass++;
        idle_inputs();
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_0100;
        @(negedge clk_in);
        n_chk++;
        if ({pc_redirect, pc_target, flush_if_id, flush_id_ex, stall} !== {1'b1, 32'h100, 2'b11, 5'd0})
            $display("FAIL branch_now: redir=%b tgt=%h fl=%b%b stall=%b",
                     pc_redirect, pc_target, flush_if_id, flush_id_ex, stall);
        else n_pass++;
        @(posedge clk_in); #1;
        n_chk++;
        if (flush_cnt !== 8'd1) $display("FAIL branch_now_cnt: flush_cnt got %0d want 1", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_branch_wait();
        logic [2:0] want;  // {stall0, discard, redirect}
        for (int t = 0; t < 5; t++) begin
            idle_inputs();
            ex_br_taken  = (t < 3);
            ex_br_target = (t == 0) ? 32'h0000_0200 : 32'h0000_0999;
            if_busy      = (t < 3);
            if_done      = (t == 3);
            want = (t < 3) ? 3'b100 : (t == 3) ? 3'b111 : 3'b000;
            @(negedge clk_in);
            n_chk++;
            if ({stall[0], if_discard, pc_redirect} !== want ||
                pc_target !== ((t == 3) ? 32'h200 : 32'h0))
                $display("FAIL branch_wait t%0d: s0/disc/redir got %b%b%b tgt %h want %b",
                         t, stall[0], if_discard, pc_redirect, pc_target, want);
            else n_pass++;
            n_chk++;
            if (dut_o !== exp_o) $display("FAIL branch_wait_model t%0d: got %h want %h", t, dut_o, exp_o);
            else n_pass++;
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_timeout();
        for (int k = 1; k <= 7; k++) begin
            idle_inputs();
            mem_busy = (k <= 5);
            @(negedge clk_in);
            n_chk++;
            if (stall !== ((k <= 5) ? 5'h1F : 5'h00))
                $display("FAIL timeout_stall k%0d: got %b", k, stall);
            else n_pass++;
            @(posedge clk_in); #1;
            n_chk++;
            if (mem_timeout !== (k >= 3)) $display("FAIL timeout k%0d: got %b want %b", k, mem_timeout, k >= 3);
            else n_pass++;
        end
    endtask

    task automatic test_mem_busy();
        int          st0;
        logic [7:0]  want_sc;
        st0 = m_stalls;
        for (int c = 0; c < 5; c++) begin
            idle_inputs();
            mem_busy = (c < 4);
            ex_br_taken = 1'b1; ex_br_target = 32'h0000_0300;
            ex_is_load = 1'b1; ex_rd_addr = 5'd7; id_read_flag_1 = 1'b1; id_reg_read_1 = 5'd7;
            @(negedge clk_in);
            n_chk++;
            if (c < 4 && (stall !== 5'h1F || pc_redirect !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0))
                $display("FAIL mem_busy c%0d: stall %b redir %b", c, stall, pc_redirect);
            else if (c == 4 && (pc_redirect !== 1'b1 || pc_target !== 32'h300))
                $display("FAIL mem_busy_release: redir %b tgt %h want 1/300", pc_redirect, pc_target);
            else n_pass++;
            @(posedge clk_in); #1;
            if (c == 3) begin
                want_sc = (st0 + 4 > SAT) ? 8'hFF : CW'(st0 + 4);
                n_chk++;
                if (stall_cnt !== want_sc) $display("FAIL mem_busy_cnt: got %0d want %0d", stall_cnt, want_sc);
                else n_pass++;
            end
        end
    endtask

    task automatic test_rdy_low_then_reset();
        logic [16:0] snap;
        idle_inputs();
        ex_br_taken = 1'b1; ex_br_target = 32'h0000_0400; if_busy = 1'b1;
        @(posedge clk_in); #1;
        snap = exp_c;
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            rdy_in = 1'b0; if_done = 1'b1; ex_br_taken = 1'b1; ex_br_target = 32'h0000_0777;
            @(negedge clk_in);
            n_chk++;
            if (dut_o !== {5'h1F, 36'd0}) $display("FAIL rdy_low c%0d: got %h want %h", c, dut_o, {5'h1F, 36'd0});
            else n_pass++;
            @(posedge clk_in); #1;
            n_chk++;
            if (dut_c !== snap) $display("FAIL rdy_low_cnt c%0d: got %h want %h", c, dut_c, snap);
            else n_pass++;
        end
        idle_inputs();
        #2 rst_n_in = 1'b0;
        #1;
        n_chk++;
        if ({dut_o, dut_c} !== 58'd0) $display("FAIL async_reset: got %h want 0", {dut_o, dut_c});
        else n_pass++;
        @(negedge clk_in); #2 rst_n_in = 1'b1;
        @(posedge clk_in); #1;
        for (int c = 0; c < 2; c++) begin
            idle_inputs();
            ex_br_taken = (c == 0); ex_br_target = 32'h0000_0500; if_done = (c == 1);
            @(negedge clk_in);
            n_chk++;
            if ({pc_redirect, pc_target} !== ((c == 0) ? {1'b1, 32'h500} : 33'd0))
                $display("FAIL post_reset c%0d: redir %b tgt %h", c, pc_redirect, pc_target);
            else n_pass++;
            @(posedge clk_in); #1;
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 800; i++) begin
            rdy_in         = ($urandom_range(0, 9) != 0);
            mem_busy       = ($urandom_range(0, 3) == 0);
            id_read_flag_1 = $urandom_range(0, 1);
            id_reg_read_1  = 5'($urandom_range(0, 3));
            id_read_flag_2 = $urandom_range(0, 1);
            id_reg_read_2  = 5'($urandom_range(0, 3));
            ex_is_load     = $urandom_range(0, 1);
            ex_rd_addr     = 5'($urandom_range(0, 3));
            ex_br_taken    = ($urandom_range(0, 3) == 0);
            ex_br_target   = $urandom;
            if_busy        = ($urandom_range(0, 4) < 2);
            if_done        = ($urandom_range(0, 4) == 0);
            @(negedge clk_in);
            n_chk++;
            if (dut_o !== exp_o) $display("FAIL random_out i%0d: got %h want %h", i, dut_o, exp_o);
            else n_pass++;
            @(posedge clk_in); #1;
            n_chk++;
            if (dut_c !== exp_c) $display("FAIL random_cnt i%0d: got %h want %h", i, dut_c, exp_c);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        idle_inputs();
        if_done = 1'b1;
        @(posedge clk_in); #1;
        for (int i = 0; i < 600; i++) begin
            idle_inputs();
            ex_br_taken  = (i < 300);
            ex_br_target = 32'h0000_1000;
            mem_busy     = (i >= 300);
            @(posedge clk_in); #1;
        end
        n_chk++;
        if ({stall_cnt, flush_cnt} !== 16'hFFFF)
            $display("FAIL saturate: stall_cnt %0d flush_cnt %0d want 255/255", stall_cnt, flush_cnt);
        else n_pass++;
        n_chk++;
        if (dut_c !== exp_c) $display("FAIL saturate_model: got %h want %h", dut_c, exp_c);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_branch_now();
        test_branch_wait();
        test_timeout();
        test_mem_busy();
        test_rdy_low_then_reset();
        test_random();
        test_saturate();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
